// File: rtl/shift_pla_atanh_seq_if.sv
// Valid/ready handshake bundle for the shift-only PLA atanh sequencer:
// tanh-domain sample in, reconstructed x plus saturation flag out.
interface shift_pla_atanh_seq_if #(
   parameter int W_IN  = 8,
   parameter int W_OUT = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [W_IN-1:0]  in;
   logic             out_valid;
   logic             out_ready;
   logic [W_OUT-1:0] out;
   logic             out_sat;

   modport master (
      output in_valid, in, out_ready,
      input  in_ready, out_valid, out, out_sat
   );

   modport slave (
      input  in_valid, in, out_ready,
      output in_ready, out_valid, out, out_sat
   );
endinterface

// File: rtl/shift_pla_atanh_seq.sv
// Sequential inverse of the shift-only piecewise-linear tanh: a bit-serial
// leading-ones scan finds the segment k, then shift/concatenate rebuilds x.
//
// state | meaning
// IDLE  | ready for a sample
// MAG   | take |y|, detect -1.0
// SCAN  | count leading fractional ones into k
// BUILD | assemble x from k and the bits after the ones run
// OUT   | hold result until accepted
module shift_pla_atanh_seq #(
   parameter int W_IN  = 8,
   parameter int W_OUT = 8,
   parameter int OUT_I = 3
) (
   input  logic                   clock,
   input  logic                   resetn,
   shift_pla_atanh_seq_if.slave   io
);
   localparam int              OUT_F = W_OUT - OUT_I;
   localparam int              KW    = OUT_I + 1;
   localparam logic [KW-1:0]   K_MAX = KW'(2 ** OUT_I);
   localparam logic [W_IN-1:0] NEG_ONE = {1'b1, {(W_IN-1){1'b0}}};
   localparam logic [W_OUT-1:0] POS_MAX = {1'b0, {(W_OUT-1){1'b1}}};

   typedef enum logic [2:0] {S_IDLE, S_MAG, S_SCAN, S_BUILD, S_OUT} state_t;

   state_t            state_q, state_d;
   logic [W_IN-1:0]   y_q, y_d;
   logic              neg_q, neg_d;
   logic              sat_q, sat_d;
   logic [KW-1:0]     k_q, k_d;
   logic [W_OUT-1:0]  out_q, out_d;
   logic              out_sat_q, out_sat_d;

   logic              scan_bit;
   logic [W_OUT-1:0]  mag_out;

   // Fraction bit j of the magnitude sits at y_q[W_IN-1-j]; scan tests j = k+1.
   always_comb begin
      int               scan_idx;
      logic [W_IN-1:0]  scan_sh;
      scan_idx = W_IN - 2 - int'(k_q);
      scan_sh  = y_q >> scan_idx;
      scan_bit = (scan_idx >= 0) ? scan_sh[0] : 1'b0;
   end

   // x = (k + t)/2, where t is the mag fraction after the leading-ones run and its 0.
   always_comb begin
      int               src;
      logic [W_IN-1:0]  src_sh;
      mag_out = '0;
      mag_out[W_OUT-2:OUT_F] = (OUT_I-1)'(k_q >> 1);
      mag_out[OUT_F-1]       = k_q[0];
      for (int m = 2; m <= OUT_F; m++) begin
         src    = m + int'(k_q);
         src_sh = y_q >> (W_IN - 1 - src);
         if (src <= W_IN - 1) mag_out[OUT_F-m] = src_sh[0];
      end
   end

   always_comb begin
      state_d   = state_q;
      y_d       = y_q;
      neg_d     = neg_q;
      sat_d     = sat_q;
      k_d       = k_q;
      out_d     = out_q;
      out_sat_d = out_sat_q;
      unique case (state_q)
         S_IDLE: begin
            if (io.in_valid) begin
               y_d     = io.in;
               neg_d   = io.in[W_IN-1];
               sat_d   = 1'b0;
               k_d     = '0;
               state_d = S_MAG;
            end
         end
         S_MAG: begin
            k_d     = '0;
            state_d = S_SCAN;
            // -1.0 has no magnitude; SCAN passes it straight to BUILD.
            if (y_q == NEG_ONE) sat_d = 1'b1;
            else if (neg_q)     y_d   = ~y_q + 1'b1;
         end
         S_SCAN: begin
            if (sat_q) begin
               state_d = S_BUILD;
            end else if (k_q == K_MAX) begin
               sat_d   = 1'b1;
               state_d = S_BUILD;
            end else if (scan_bit) begin
               if (int'(k_q) + 1 == W_IN - 1) begin
                  sat_d   = 1'b1;
                  state_d = S_BUILD;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end else begin
               state_d = S_BUILD;
            end
         end
         S_BUILD: begin
            if (sat_q) out_d = neg_q ? (~POS_MAX + 1'b1) : POS_MAX;
            else       out_d = neg_q ? (~mag_out + 1'b1) : mag_out;
            out_sat_d = sat_q;
            state_d   = S_OUT;
         end
         S_OUT: begin
            if (io.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         y_q       <= '0;
         neg_q     <= 1'b0;
         sat_q     <= 1'b0;
         k_q       <= '0;
         out_q     <= '0;
         out_sat_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         y_q       <= y_d;
         neg_q     <= neg_d;
         sat_q     <= sat_d;
         k_q       <= k_d;
         out_q     <= out_d;
         out_sat_q <= out_sat_d;
      end
   end

   assign io.in_ready  = resetn && (state_q == S_IDLE);
   assign io.out_valid = (state_q == S_OUT);
   assign io.out       = out_q;
   assign io.out_sat   = out_sat_q;
endmodule
